key_buffer: RTL

- Key-side responder for expandKey's key interface. Accepts the password as a byte stream and appends the bcrypt NUL terminator.
- Builds a cyclically repeated 72-byte key image. It then serves 8-byte windows {key[a]..key[a+7]} for any byte address a driven on key_addr.
- Sits between the host/password loader and expandKey. It replaces the flat key array that expandKey would otherwise index directly.

---
 rtl/key_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/key_buffer.sv
// key_buffer: key-side responder for expandKey.
// Accepts a password as a byte stream, appends the bcrypt NUL terminator,
// then builds a cyclically repeated MAX_KEY_BYTES-byte key image. In READY
// it serves 8-byte windows {key[a]..key[a+7]} (wrapping inside the image)
// with one cycle of latency from key_addr.
//
// Ports:
//   clk, reset_l          clock, synchronous active-low reset
//   clear                 discard current key and return to LOAD
//   pw_byte/valid/keep/last, pw_ready   password byte stream
//   key_addr, key_data    window start address / 64-bit window
//   key_ready             expanded image valid
//   key_len               stored length including NUL
//   truncated             password exceeded MAX_KEY_BYTES-1 bytes
module key_buffer #(
  parameter int MAX_KEY_BYTES = 72
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        clear,
  input  logic [7:0]  pw_byte,
  input  logic        pw_valid,
  input  logic        pw_keep,
  input  logic        pw_last,
  output logic        pw_ready,
  input  logic [6:0]  key_addr,
  output logic [63:0] key_data,
  output logic        key_ready,
  output logic [6:0]  key_len,
  output logic        truncated
);

  typedef enum logic [1:0] {LOAD, TERM, EXPAND, READY} state_t;

  localparam logic [6:0] MAX_LEN  = 7'(MAX_KEY_BYTES);
  localparam logic [6:0] LAST_IDX = 7'(MAX_KEY_BYTES - 1);
  localparam logic [7:0] WRAP     = 8'(MAX_KEY_BYTES);

  state_t      state;
  logic [7:0]  raw_mem [MAX_KEY_BYTES];
  logic [7:0]  exp_mem [MAX_KEY_BYTES];
  logic [6:0]  len;
  logic [6:0]  src;
  logic [6:0]  dst;
  logic        accept;
  logic [63:0] window;
  logic [7:0]  idx;

  assign pw_ready = (state == LOAD) && !clear;
  assign accept   = pw_valid && pw_ready;

  // Window gather: index math in 8 bits so a+k (up to 78) cannot overflow
  // before the single wrap subtraction.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = {1'b0, key_addr} + 8'(k);
      if (idx >= WRAP) idx = idx - WRAP;
      window[8*(7-k) +: 8] = exp_mem[idx[6:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= LOAD;
      key_ready <= 1'b0;
      key_data  <= '0;
      key_len   <= '0;
      truncated <= 1'b0;
      len       <= '0;
      src       <= '0;
      dst       <= '0;
    end else if (clear) begin
      state     <= LOAD;
      key_ready <= 1'b0;
      key_data  <= '0;
      key_len   <= '0;
      truncated <= 1'b0;
      len       <= '0;
      src       <= '0;
      dst       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (pw_keep) begin
              if (len < MAX_LEN) begin
                raw_mem[len] <= pw_byte;
                len          <= len + 7'd1;
              end else begin
                truncated <= 1'b1;
              end
            end
            if (pw_last) state <= TERM;
          end
        end
        TERM: begin
          if (len < MAX_LEN) begin
            raw_mem[len] <= '0;
            len          <= len + 7'd1;
            key_len      <= len + 7'd1;
          end else begin
            truncated <= 1'b1;
            key_len   <= len;
          end
          src   <= '0;
          dst   <= '0;
          state <= EXPAND;
        end
        EXPAND: begin
          exp_mem[dst] <= raw_mem[src];
          dst          <= dst + 7'd1;
          src          <= (src + 7'd1 == len) ? 7'd0 : src + 7'd1;
          if (dst == LAST_IDX) begin
            state     <= READY;
            key_ready <= 1'b1;
          end
        end
        READY: begin
          key_data <= (key_addr <= LAST_IDX) ? window : '0;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
